// File: rtl/hamming_secded_decoder_if.sv
// Stream bundle for the SECDED decoder: received codeword in, decoded word out.
interface hamming_secded_decoder_if #(
  parameter int unsigned DATA_W = 4
);
  localparam int unsigned P     = (DATA_W <= 4)  ? 3 :
                                  (DATA_W <= 11) ? 4 :
                                  (DATA_W <= 26) ? 5 : 6;
  localparam int unsigned CW_W  = DATA_W + P + 1;
  localparam int unsigned POS_W = P;

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CW_W-1:0]   out_cw;
  logic              out_sec;
  logic              out_ded;
  logic [POS_W:0]    out_err_pos;

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_data, out_cw, out_sec, out_ded, out_err_pos
  );

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_data, out_cw, out_sec, out_ded, out_err_pos
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder (extended Hamming, overall parity in bit 0)
// with valid/ready flow control, detect-only mode and saturating error counters.
module hamming_secded_decoder #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    corr_en,
  input  logic                    clr_cnt,
  hamming_secded_decoder_if.slave bus,
  output logic [CNT_W-1:0]        sec_count,
  output logic [CNT_W-1:0]        ded_count
);
  localparam int unsigned P     = (DATA_W <= 4)  ? 3 :
                                  (DATA_W <= 11) ? 4 :
                                  (DATA_W <= 26) ? 5 : 6;
  localparam int unsigned CW_W  = DATA_W + P + 1;
  localparam int unsigned POS_W = P;
  localparam int unsigned EP_W  = POS_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Positions covered by syndrome bit j: every k in 1..CW_W-1 with k[j] set.
  function automatic logic [CW_W-1:0] f_syn_mask(input int unsigned j);
    logic [CW_W-1:0] m;
    m = '0;
    for (int unsigned k = 1; k < CW_W; k++) begin
      if (((k >> j) & 1) != 0) m = m | (CW_W'(1) << k);
    end
    return m;
  endfunction

  // Hamming position holding data bit i: i-th non-power-of-two position from 3 up.
  function automatic int unsigned f_data_pos(input int unsigned i);
    int unsigned n;
    int unsigned pos;
    n   = 0;
    pos = 0;
    for (int unsigned k = 3; k < CW_W; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (n == i) pos = k;
        n = n + 1;
      end
    end
    return pos;
  endfunction

  logic              w_adv;
  logic [P-1:0]      w_syn;
  logic              w_par;
  logic              w_in_range;
  logic              w_sec;
  logic              w_ded;
  logic [CW_W-1:0]   w_cw;
  logic [EP_W-1:0]   w_pos;
  logic [DATA_W-1:0] w_data;
  logic              w_deliver;

  logic              r_s1_valid;
  logic [P-1:0]      r_s1_syn;
  logic              r_s1_par;
  logic [CW_W-1:0]   r_s1_cw;
  logic              r_s1_corr;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_data;
  logic [CW_W-1:0]   r_cw;
  logic              r_sec;
  logic              r_ded;
  logic [EP_W-1:0]   r_pos;
  logic [CNT_W-1:0]  r_sec_cnt;
  logic [CNT_W-1:0]  r_ded_cnt;

  // Both stages move together whenever the output slot is free or being drained.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Stage-1 syndrome and overall parity.
  for (genvar j = 0; j < P; j++) begin : g_syn
    localparam logic [CW_W-1:0] MASK = f_syn_mask(j);
    assign w_syn[j] = ^(bus.in_cw & MASK);
  end
  assign w_par = ^bus.in_cw;

  // Stage-2 classification; syndromes beyond the last position only occur in shortened codes.
  always_comb begin
    w_in_range = ({1'b0, r_s1_syn} < EP_W'(CW_W));
    w_sec      = r_s1_par && w_in_range;
    w_ded      = r_s1_par ? !w_in_range : (r_s1_syn != '0);
    w_pos      = w_sec ? {1'b0, r_s1_syn} : '0;
    w_cw       = r_s1_cw;
    if (w_sec && r_s1_corr) w_cw = r_s1_cw ^ (CW_W'(1) << r_s1_syn);
  end

  // Data is taken from the codeword exactly as it will be presented.
  for (genvar i = 0; i < DATA_W; i++) begin : g_ext
    localparam int unsigned POS = f_data_pos(i);
    assign w_data[i] = w_cw[POS];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_syn    <= '0;
      r_s1_par    <= 1'b0;
      r_s1_cw     <= '0;
      r_s1_corr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_cw        <= '0;
      r_sec       <= 1'b0;
      r_ded       <= 1'b0;
      r_pos       <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_syn    <= w_syn;
      r_s1_par    <= w_par;
      r_s1_cw     <= bus.in_cw;
      r_s1_corr   <= corr_en;
      r_out_valid <= r_s1_valid;
      r_data      <= w_data;
      r_cw        <= w_cw;
      r_sec       <= w_sec;
      r_ded       <= w_ded;
      r_pos       <= w_pos;
    end
  end

  // Counters see a word only when it is actually handed to the consumer.
  assign w_deliver = r_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (clr_cnt) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else begin
      if (w_deliver && r_sec && (r_sec_cnt != CNT_MAX)) r_sec_cnt <= r_sec_cnt + 1'b1;
      if (w_deliver && r_ded && (r_ded_cnt != CNT_MAX)) r_ded_cnt <= r_ded_cnt + 1'b1;
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_data;
  assign bus.out_cw      = r_cw;
  assign bus.out_sec     = r_sec;
  assign bus.out_ded     = r_ded;
  assign bus.out_err_pos = r_pos;
  assign sec_count       = r_sec_cnt;
  assign ded_count       = r_ded_cnt;
endmodule
